// File: rtl/fp_pkg.sv
// Shared FP16 field geometry, constants and flag layout for the
// normalize-round-pack datapath.
package fp_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP16_BIAS   = 15;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [4:0]  FP16_INF_EXP  = 5'h1F;

    // Bit positions inside the 3-bit {overflow, underflow, inexact} flag word
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;

    // Assemble a binary16 word from its fields
    function automatic logic [15:0] fp16_pack(
        input logic                   sign,
        input logic [FP16_EXP_W-1:0]  exp,
        input logic [FP16_FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-one position encoder: reports the index of the highest set bit
// and whether the word is all zeros. Purely combinational.
module fp_lzc #(
    parameter int WIDTH = 16,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Scan from LSB upward so the highest set bit overwrites lower ones
    always_comb begin
        pos  = {POS_W{1'b0}};
        zero = (value == {WIDTH{1'b0}});
        for (int i = 0; i < WIDTH; i++) begin
            pos = value[i] ? POS_W'(i) : pos;
        end
    end

endmodule

// File: rtl/fp_norm_pack.sv
// Three-stage normalize / round-to-nearest-even / pack stage turning the
// adder's unnormalized sum into a binary16 word with exception flags.
// All stages move together on 'advance_s', so a stalled output freezes
// the whole pipe and bubbles are kept.
module fp_norm_pack
    import fp_pkg::*;
#(
    parameter int EXP_LEN = 6,
    parameter int IN_BIAS = 31,
    parameter int MAN_LEN = 16,
    parameter int INT_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_LEN-1:0] in_exp,
    input  logic [MAN_LEN-1:0] in_man,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_fp16,
    output logic [2:0]         out_flags
);

    localparam int FRAC_LEN = MAN_LEN - INT_LEN;
    localparam int POS_W    = $clog2(MAN_LEN);
    localparam int E_W      = EXP_LEN + 3;
    localparam int LOW_W    = MAN_LEN - 1;             // bits below the leading one
    localparam int GUARD_IX = LOW_W - 1 - FP16_FRAC_W; // first bit below the kept fraction

    localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
    localparam logic signed [E_W-1:0] E_MAX = E_W'(31);

    // ---------------- stage 1: capture + leading-one detect ----------------
    logic               advance_s;
    logic [POS_W-1:0]   lzc_pos_s;
    logic               lzc_zero_s;

    logic               v1_r;
    logic               s1_sign_r;
    logic [EXP_LEN-1:0] s1_exp_r;
    logic [LOW_W-1:0]   s1_man_r;  // MSB of in_man only matters to the encoder
    logic [POS_W-1:0]   s1_pos_r;
    logic               s1_zero_r;

    // ---------------- stage 2: normalize + exponent ----------------
    logic [POS_W-1:0]      shamt_s;
    logic [LOW_W-1:0]      norm_low_s;
    logic signed [E_W-1:0] exp_calc_s;

    logic                  v2_r;
    logic                  s2_sign_r;
    logic                  s2_zero_r;
    logic [LOW_W-1:0]      s2_man_r;
    logic signed [E_W-1:0] s2_exp_r;

    // ---------------- stage 3: round + pack ----------------
    logic [FP16_FRAC_W-1:0] frac_s;
    logic                   guard_s;
    logic                   sticky_s;
    logic                   round_up_s;
    logic [FP16_FRAC_W:0]   frac_sum_s;
    logic signed [E_W-1:0]  exp_rnd_s;
    logic [15:0]            res_fp16_s;
    logic [2:0]             res_flags_s;

    logic                   v3_r;
    logic [15:0]            out_fp16_r;
    logic [2:0]             out_flags_r;

    assign advance_s = ~v3_r | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = v3_r;
    assign out_fp16  = out_fp16_r;
    assign out_flags = out_flags_r;

    fp_lzc #(
        .WIDTH (MAN_LEN),
        .POS_W (POS_W)
    ) u_lzc (
        .value (in_man),
        .pos   (lzc_pos_s),
        .zero  (lzc_zero_s)
    );

    // Stage 1 register: capture the beat together with its leading-one position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_r      <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_exp_r  <= {EXP_LEN{1'b0}};
            s1_man_r  <= {LOW_W{1'b0}};
            s1_pos_r  <= {POS_W{1'b0}};
            s1_zero_r <= 1'b0;
        end else if (advance_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= in_sign;
                s1_exp_r  <= in_exp;
                s1_man_r  <= in_man[LOW_W-1:0];
                s1_pos_r  <= lzc_pos_s;
                s1_zero_r <= lzc_zero_s;
            end
        end
    end

    // Normalize so the leading one sits just above s2_man_r, and rebias the
    // exponent in a widened signed range so out-of-range values never wrap
    always_comb begin
        shamt_s    = POS_W'(MAN_LEN - 1) - s1_pos_r;
        norm_low_s = s1_man_r << shamt_s;
        exp_calc_s = E_W'(s1_exp_r) + E_W'(s1_pos_r)
                   + E_W'(FP16_BIAS - IN_BIAS - FRAC_LEN);
    end

    // Stage 2 register: normalized magnitude and output-biased exponent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_r      <= 1'b0;
            s2_sign_r <= 1'b0;
            s2_zero_r <= 1'b0;
            s2_man_r  <= {LOW_W{1'b0}};
            s2_exp_r  <= {E_W{1'b0}};
        end else if (advance_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                s2_sign_r <= s1_sign_r;
                s2_zero_r <= s1_zero_r;
                s2_man_r  <= norm_low_s;
                s2_exp_r  <= exp_calc_s;
            end
        end
    end

    // Round to nearest even; a fraction carry-out rolls into the exponent
    always_comb begin
        frac_s     = s2_man_r[LOW_W-1 -: FP16_FRAC_W];
        guard_s    = s2_man_r[GUARD_IX];
        sticky_s   = |s2_man_r[GUARD_IX-1:0];
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        frac_sum_s = {1'b0, frac_s} + {{FP16_FRAC_W{1'b0}}, round_up_s};
        exp_rnd_s  = s2_exp_r + E_W'(frac_sum_s[FP16_FRAC_W]);
    end

    // Classify the rounded result: zero, overflow to infinity, flush, or normal
    always_comb begin
        res_fp16_s  = FP16_POS_ZERO;
        res_flags_s = 3'b000;
        if (s2_zero_r) begin
            res_fp16_s  = FP16_POS_ZERO;
            res_flags_s = 3'b000;
        end else if (exp_rnd_s >= E_MAX) begin
            res_fp16_s                  = fp16_pack(s2_sign_r, FP16_INF_EXP, {FP16_FRAC_W{1'b0}});
            res_flags_s[FLAG_OVERFLOW]  = 1'b1;
            res_flags_s[FLAG_INEXACT]   = 1'b1;
        end else if (s2_exp_r < E_ONE) begin
            res_fp16_s                  = fp16_pack(s2_sign_r, {FP16_EXP_W{1'b0}}, {FP16_FRAC_W{1'b0}});
            res_flags_s[FLAG_UNDERFLOW] = 1'b1;
            res_flags_s[FLAG_INEXACT]   = 1'b1;
        end else begin
            res_fp16_s                  = fp16_pack(s2_sign_r, exp_rnd_s[FP16_EXP_W-1:0],
                                                    frac_sum_s[FP16_FRAC_W-1:0]);
            res_flags_s[FLAG_INEXACT]   = guard_s | sticky_s;
        end
    end

    // Stage 3 / output register: held while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v3_r        <= 1'b0;
            out_fp16_r  <= 16'h0000;
            out_flags_r <= 3'b000;
        end else if (advance_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_fp16_r  <= res_fp16_s;
                out_flags_r <= res_flags_s;
            end
        end
    end

endmodule
